// File: rtl/paddle_ctrl.sv
// paddle_ctrl: per-frame pong paddle position controller with speed ramp and clamping.
// Optional ball tracking is enabled by defining AUTO_TRACK_EN (adds auto_mode and ball_y ports).
module paddle_ctrl #(
  parameter int PADDLE_HEIGHT = 100,
  parameter int V_RES         = 480,
  parameter int START_Y       = 190,
  parameter int SPEED_MIN     = 2,
  parameter int SPEED_MAX     = 8,
  parameter int RAMP_FRAMES   = 8
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       frame,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       serve,
`ifdef AUTO_TRACK_EN
  input  logic       auto_mode,
  input  logic [9:0] ball_y,
`endif
  output logic [9:0] pad_top_pixel,
  output logic       moving
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  localparam logic [10:0] LIM  = 11'(V_RES - PADDLE_HEIGHT);
  localparam logic [7:0]  SMIN = 8'(SPEED_MIN);
  localparam logic [7:0]  SMAX = 8'(SPEED_MAX);
  localparam logic [7:0]  RAMP = 8'(RAMP_FRAMES);
  state_t state, state_n, req;
  logic [1:0] up_sync, dn_sync;
  logic [7:0] speed, speed_n, cnt, cnt_n, spd_eff, cnt_inc;
  logic [10:0] pad, spd11, pad_mv;
  logic [9:0] pad_n;
  logic moved, moving_n, ramp, fixed_speed;
`ifdef AUTO_TRACK_EN
  logic signed [10:0] tgt_s;
  logic [10:0] tgt;
  always_comb begin
    tgt_s = $signed({1'b0, ball_y}) - $signed(11'(PADDLE_HEIGHT / 2));
    tgt   = tgt_s[10] ? 11'd0 : (11'(tgt_s) > LIM ? LIM : 11'(tgt_s));
  end
  assign fixed_speed = auto_mode;
  assign req = auto_mode ? ((pad + 11'd4 < tgt) ? DOWN : (pad > tgt + 11'd4) ? UP : IDLE)
             : (up_sync[1] & ~dn_sync[1]) ? UP : (dn_sync[1] & ~up_sync[1]) ? DOWN : IDLE;
`else
  assign fixed_speed = 1'b0;
  assign req = (up_sync[1] & ~dn_sync[1]) ? UP : (dn_sync[1] & ~up_sync[1]) ? DOWN : IDLE;
`endif
  assign pad = {1'b0, pad_top_pixel};
  // A fresh direction restarts the ramp; the clamp test uses the speed actually applied.
  assign spd_eff = (state != req || fixed_speed) ? SMIN : speed;
  assign spd11   = {3'b0, spd_eff};
  assign pad_mv  = req == UP   ? (pad < spd11 ? 11'd0 : pad - spd11)
                 : req == DOWN ? (pad + spd11 > LIM ? LIM : pad + spd11) : pad;
  assign moved   = pad_mv != pad;
  assign cnt_inc = (state != req ? 8'd0 : cnt) + {7'd0, moved};
  assign ramp    = cnt_inc == RAMP;
  always_comb begin
    state_n  = state;
    speed_n  = speed;
    cnt_n    = cnt;
    pad_n    = pad_top_pixel;
    moving_n = moving;
    if (serve) begin
      state_n  = IDLE;
      speed_n  = SMIN;
      cnt_n    = 8'd0;
      pad_n    = 10'(START_Y);
      moving_n = 1'b0;
    end else if (frame) begin
      state_n  = req;
      pad_n    = pad_mv[9:0];
      moving_n = moved;
      speed_n  = (req == IDLE || fixed_speed) ? SMIN
               : ramp ? (spd_eff >= SMAX ? SMAX : spd_eff + 8'd1) : spd_eff;
      cnt_n    = (req == IDLE || fixed_speed || ramp) ? 8'd0 : cnt_inc;
    end
  end
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      up_sync       <= 2'b0;
      dn_sync       <= 2'b0;
      state         <= IDLE;
      speed         <= SMIN;
      cnt           <= 8'd0;
      pad_top_pixel <= 10'(START_Y);
      moving        <= 1'b0;
    end else begin
      up_sync       <= {up_sync[0], btn_up};
      dn_sync       <= {dn_sync[0], btn_down};
      state         <= state_n;
      speed         <= speed_n;
      cnt           <= cnt_n;
      pad_top_pixel <= pad_n;
      moving        <= moving_n;
    end
  end
endmodule
